// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares the single PL-side BRAM port between two requesters (0: DMA refresh reader,
// 1: synth/capture writer). Grants are round-robin with bursts bounded by MAX_BURST.
// Every BRAM-facing signal is registered, and read data is routed back to the
// requester that issued the read after RD_LAT cycles.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   rK_req/we/addr/wdata     beat request from requester K, held until rK_ack
//   rK_ack                   beat accepted on this rising edge (combinational)
//   rK_rvalid/rK_rdata       one-cycle read-data pulse for requester K
//   BRAM_*                   block-design port B pins (addr/din/we/en registered,
//                            clk/rst passed through, dout from the BRAM)
module bram_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic [3:0]        r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic [3:0]        r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] BRAM_addr,
    output logic [DATA_W-1:0] BRAM_din,
    output logic [3:0]        BRAM_we,
    output logic              BRAM_en,
    output logic              BRAM_clk,
    output logic              BRAM_rst,
    input  logic [DATA_W-1:0] BRAM_dout
);

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e      state_q;
    logic        last_q;
    logic [7:0]  beats_q;
    logic [7:0]  beats_inc;

    logic              beat;
    logic [3:0]        sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Issue-stage tag travelling alongside BRAM_en, then the RD_LAT-deep tracking pipe.
    logic              issue_rd_q;
    logic              issue_id_q;
    logic [RD_LAT-1:0] pipe_valid_q;
    logic [RD_LAT-1:0] pipe_id_q;

    assign BRAM_clk = clk;
    assign BRAM_rst = rst;

    always_comb begin
        r0_ack    = (state_q == StOwn0) && r0_req;
        r1_ack    = (state_q == StOwn1) && r1_req;
        beat      = r0_ack || r1_ack;
        beats_inc = beats_q + 8'd1;
        if (r1_ack) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end else begin
            sel_we    = r0_we;
            sel_addr  = r0_addr;
            sel_wdata = r0_wdata;
        end
    end

    // Arbitration FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            beats_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    beats_q <= '0;
                    // On a tie the requester that was not served last wins.
                    if (r0_req && (!r1_req || last_q)) begin
                        state_q <= StOwn0;
                    end else if (r1_req) begin
                        state_q <= StOwn1;
                    end
                end
                StOwn0: begin
                    if (!r0_req) begin
                        beats_q <= '0;
                        state_q <= r1_req ? StOwn1 : StIdle;
                    end else begin
                        last_q <= 1'b0;
                        if (beats_inc == MaxBurst) begin
                            // Burst limit: restart the count even if we keep the port.
                            beats_q <= '0;
                            if (r1_req) begin
                                state_q <= StOwn1;
                            end
                        end else begin
                            beats_q <= beats_inc;
                        end
                    end
                end
                StOwn1: begin
                    if (!r1_req) begin
                        beats_q <= '0;
                        state_q <= r0_req ? StOwn0 : StIdle;
                    end else begin
                        last_q <= 1'b1;
                        if (beats_inc == MaxBurst) begin
                            beats_q <= '0;
                            if (r0_req) begin
                                state_q <= StOwn0;
                            end
                        end else begin
                            beats_q <= beats_inc;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    beats_q <= '0;
                end
            endcase
        end
    end

    // Issue registers and read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            BRAM_en      <= 1'b0;
            BRAM_we      <= 4'h0;
            BRAM_addr    <= '0;
            BRAM_din     <= '0;
            issue_rd_q   <= 1'b0;
            issue_id_q   <= 1'b0;
            pipe_valid_q <= '0;
            pipe_id_q    <= '0;
        end else begin
            BRAM_en    <= beat;
            BRAM_we    <= beat ? sel_we : 4'h0;
            issue_rd_q <= beat && (sel_we == 4'h0);
            issue_id_q <= r1_ack;
            if (beat) begin
                // BRAM is word-addressed in bytes; force word alignment.
                BRAM_addr <= sel_addr & ~ADDR_W'(3);
                BRAM_din  <= sel_wdata;
            end
            pipe_valid_q <= (pipe_valid_q << 1) | RD_LAT'(issue_rd_q);
            pipe_id_q    <= (pipe_id_q << 1) | RD_LAT'(issue_id_q);
        end
    end

    always_comb begin
        r0_rvalid = pipe_valid_q[RD_LAT-1] && !pipe_id_q[RD_LAT-1];
        r1_rvalid = pipe_valid_q[RD_LAT-1] && pipe_id_q[RD_LAT-1];
        r0_rdata  = r0_rvalid ? BRAM_dout : '0;
        r1_rdata  = r1_rvalid ? BRAM_dout : '0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus a randomized
// run scored against a cycle-level behavioural model and a shadow memory.
module tb_bram_port_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned MAX_BURST = 4;
    localparam int          NRAND     = 400;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [3:0]  r0_we = 4'h0, r1_we = 4'h0;
    logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
    logic        r0_ack, r1_ack, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
    logic [3:0]  BRAM_we;
    logic        BRAM_en, BRAM_clk, BRAM_rst;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .BRAM_addr(BRAM_addr), .BRAM_din(BRAM_din), .BRAM_we(BRAM_we), .BRAM_en(BRAM_en),
        .BRAM_clk(BRAM_clk), .BRAM_rst(BRAM_rst), .BRAM_dout(BRAM_dout)
    );

    function automatic logic [31:0] pattern(int idx);
        return 32'hCAFE0000 | 32'(idx << 2);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // BRAM model: word at byte address A initially 0xCAFE0000|A, data RD_LAT after en.
    logic [31:0] mem [1024];
    logic        mem_wr [1024] = '{default: 1'b0};
    logic [31:0] dly [RD_LAT] = '{default: 32'h0};
    logic [31:0] cur_word;

    assign cur_word  = mem_wr[BRAM_addr[11:2]] ? mem[BRAM_addr[11:2]] : pattern(int'(BRAM_addr[11:2]));
    assign BRAM_dout = dly[RD_LAT-1];

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= BRAM_en ? cur_word : 32'h0;
        if (BRAM_en && BRAM_we != 4'h0) begin
            mem[BRAM_addr[11:2]]    <= merge(cur_word, BRAM_din, BRAM_we);
            mem_wr[BRAM_addr[11:2]] <= 1'b1;
        end
    end

    // Requester protocol: fields stay put while a request is pending and unacked.
    logic        h0_v = 1'b0, h1_v = 1'b0;
    logic [67:0] h0_f, h1_f;
    always @(posedge clk) begin
        if (h0_v && r0_req) assert ({r0_we, r0_addr, r0_wdata} == h0_f);
        if (h1_v && r1_req) assert ({r1_we, r1_addr, r1_wdata} == h1_f);
        h0_v <= r0_req && !r0_ack && !rst;
        h1_v <= r1_req && !r1_ack && !rst;
        h0_f <= {r0_we, r0_addr, r0_wdata};
        h1_f <= {r1_we, r1_addr, r1_wdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0_req = 1'b0;
        r1_req = 1'b0;
        rst    = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 32'h4;  r0_wdata = 32'h1111;
        r1_req = 1'b1; r1_we = 4'hF; r1_addr = 32'h8;  r1_wdata = 32'h2222;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({r0_ack, r1_ack, r0_rvalid, r1_rvalid, BRAM_en} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_ctrl cyc %0d got %b want 00000", c,
                         {r0_ack, r1_ack, r0_rvalid, r1_rvalid, BRAM_en});
            end
            n_cmp++;
            if ({BRAM_we, BRAM_addr, BRAM_din, r0_rdata, r1_rdata} !== '0) begin
                n_err++;
                $display("FAIL reset_data cyc %0d we %h addr %h din %h rd0 %h rd1 %h want 0",
                         c, BRAM_we, BRAM_addr, BRAM_din, r0_rdata, r1_rdata);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r0_ack, r1_ack} !== 2'b00) begin
            n_err++; $display("FAIL reset_bubble acks %b want 00", {r0_ack, r1_ack});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({r0_ack, r1_ack} !== 2'b10) begin
            n_err++; $display("FAIL reset_first_tie acks %b want 10", {r0_ack, r1_ack});
        end
        tick();
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 32'h13;
        @(negedge clk);
        n_cmp++;
        if (r0_ack !== 1'b0) begin n_err++; $display("FAIL single_c0_ack got %b want 0", r0_ack); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (r0_ack !== 1'b1) begin n_err++; $display("FAIL single_c1_ack got %b want 1", r0_ack); end
        tick();
        r0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({BRAM_en, BRAM_we, BRAM_addr} !== {1'b1, 4'h0, 32'h10}) begin
            n_err++;
            $display("FAIL single_issue en %b we %h addr %h want 1 0 00000010", BRAM_en, BRAM_we, BRAM_addr);
        end
        for (int c = 3; c < 7; c++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if ({r0_rvalid, r1_rvalid} !== {c == 4, 1'b0}) begin
                n_err++;
                $display("FAIL single_rvalid cyc %0d got %b want %b", c, {r0_rvalid, r1_rvalid}, {c == 4, 1'b0});
            end
            if (c == 4) begin
                n_cmp++;
                if (r0_rdata !== 32'hCAFE0010) begin
                    n_err++; $display("FAIL single_rdata got %h want cafe0010", r0_rdata);
                end
            end
        end
    endtask

    task automatic test_contention();
        int grp;
        logic e0, e1;
        do_reset();
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 32'h100;
        r1_req = 1'b1; r1_we = 4'h0; r1_addr = 32'h200;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            grp = (c - 1) / int'(MAX_BURST);
            e0  = (c > 0) && (grp % 2 == 0);
            e1  = (c > 0) && (grp % 2 == 1);
            n_cmp++;
            if ({r0_ack, r1_ack} !== {e0, e1}) begin
                n_err++; $display("FAIL contention cyc %0d acks %b want %b", c, {r0_ack, r1_ack}, {e0, e1});
            end
            tick();
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic test_solo_stream();
        logic exp_rv;
        do_reset();
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 32'h0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_cmp++;
            if (r0_ack !== (c >= 1 && c <= 10)) begin
                n_err++; $display("FAIL solo_ack cyc %0d got %b want %b", c, r0_ack, (c >= 1 && c <= 10));
            end
            exp_rv = (c >= 4 && c <= 13);
            n_cmp++;
            if (r0_rvalid !== exp_rv) begin
                n_err++; $display("FAIL solo_rvalid cyc %0d got %b want %b", c, r0_rvalid, exp_rv);
            end else if (exp_rv) begin
                n_cmp++;
                if (r0_rdata !== pattern(c - 4)) begin
                    n_err++; $display("FAIL solo_rdata cyc %0d got %h want %h", c, r0_rdata, pattern(c - 4));
                end
            end
            tick();
            if (c >= 1 && c <= 10) r0_addr = r0_addr + 32'h4;
            if (c == 10) r0_req = 1'b0;
        end
    endtask

    task automatic test_write();
        do_reset();
        r1_req = 1'b1; r1_we = 4'hF; r1_addr = 32'h20; r1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if (r1_ack !== 1'b0) begin n_err++; $display("FAIL write_c0_ack got %b want 0", r1_ack); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (r1_ack !== 1'b1) begin n_err++; $display("FAIL write_c1_ack got %b want 1", r1_ack); end
        tick();
        r1_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({BRAM_en, BRAM_we, BRAM_addr, BRAM_din} !== {1'b1, 4'hF, 32'h20, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL write_issue en %b we %h addr %h din %h want 1 f 00000020 deadbeef",
                     BRAM_en, BRAM_we, BRAM_addr, BRAM_din);
        end
        for (int c = 3; c < 8; c++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if ({r1_rvalid, r0_rvalid, BRAM_en, BRAM_we} !== 7'b0) begin
                n_err++;
                $display("FAIL write_after cyc %0d rv1 %b rv0 %b en %b we %h want all 0",
                         c, r1_rvalid, r0_rvalid, BRAM_en, BRAM_we);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        r0_req = 1'b1; r0_we = 4'h0; r0_addr = 32'h40;
        tick();
        @(negedge clk);
        n_cmp++;
        if (r0_ack !== 1'b1) begin n_err++; $display("FAIL midrst_ack1 got %b want 1", r0_ack); end
        tick();
        r0_addr = 32'h44;
        @(negedge clk);
        n_cmp++;
        if ({r0_ack, BRAM_en} !== 2'b11) begin
            n_err++; $display("FAIL midrst_ack2 ack/en %b want 11", {r0_ack, BRAM_en});
        end
        tick();
        r0_addr = 32'h48;
        rst     = 1'b1;
        tick();
        rst    = 1'b0;
        r0_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({BRAM_en, BRAM_we, BRAM_addr, BRAM_din} !== '0) begin
            n_err++;
            $display("FAIL midrst_bram en %b we %h addr %h din %h want 0", BRAM_en, BRAM_we, BRAM_addr, BRAM_din);
        end
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
                n_err++; $display("FAIL midrst_rvalid cyc %0d got %b want 00", c, {r0_rvalid, r1_rvalid});
            end
            tick();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] sh [1024];
        rd_t         q0[$], q1[$];
        rd_t         item;
        int          owner, cnt, last;
        logic        e0, e1, seen0, seen1, me_req, ot_req, exp_rv;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr, exp_din;
        for (int i = 0; i < 1024; i++) sh[i] = pattern(i);
        do_reset();
        owner = -1; cnt = 0; last = 1;
        exp_en = 1'b0; exp_we = 4'h0; exp_addr = '0; exp_din = '0;
        seen0 = 1'b0; seen1 = 1'b0;
        for (int c = 0; c < NRAND + 30; c++) begin
            if (!r0_req || seen0) begin
                r0_req   = (c < NRAND) && ($urandom_range(0, 9) < 7);
                r0_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                r0_addr  = 32'h800 + 32'($urandom_range(0, 255));
                r0_wdata = $urandom;
            end
            if (!r1_req || seen1) begin
                r1_req   = (c < NRAND) && ($urandom_range(0, 9) < 6);
                r1_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                r1_addr  = 32'h800 + 32'($urandom_range(0, 255));
                r1_wdata = $urandom;
            end
            @(negedge clk);
            e0 = (owner == 0) && r0_req;
            e1 = (owner == 1) && r1_req;
            n_cmp++;
            if ({r0_ack, r1_ack} !== {e0, e1}) begin
                n_err++; $display("FAIL rand_ack cyc %0d got %b want %b", c, {r0_ack, r1_ack}, {e0, e1});
            end
            n_cmp++;
            if (BRAM_en !== exp_en || (exp_en &&
                {BRAM_we, BRAM_addr, BRAM_din} !== {exp_we, exp_addr, exp_din})) begin
                n_err++;
                $display("FAIL rand_issue cyc %0d en %b we %h addr %h din %h want %b %h %h %h",
                         c, BRAM_en, BRAM_we, BRAM_addr, BRAM_din, exp_en, exp_we, exp_addr, exp_din);
            end
            exp_rv = (q0.size() > 0) && (q0[0].due == c);
            n_cmp++;
            if (r0_rvalid !== exp_rv || (exp_rv && r0_rdata !== q0[0].data)) begin
                n_err++;
                $display("FAIL rand_read0 cyc %0d rv %b data %h want %b %h", c, r0_rvalid, r0_rdata,
                         exp_rv, exp_rv ? q0[0].data : 32'h0);
            end
            if (exp_rv) void'(q0.pop_front());
            exp_rv = (q1.size() > 0) && (q1[0].due == c);
            n_cmp++;
            if (r1_rvalid !== exp_rv || (exp_rv && r1_rdata !== q1[0].data)) begin
                n_err++;
                $display("FAIL rand_read1 cyc %0d rv %b data %h want %b %h", c, r1_rvalid, r1_rdata,
                         exp_rv, exp_rv ? q1[0].data : 32'h0);
            end
            if (exp_rv) void'(q1.pop_front());
            seen0 = r0_ack;
            seen1 = r1_ack;

            // Model: what the port does on the coming edge.
            exp_en = e0 || e1;
            exp_we = 4'h0;
            if (e0 || e1) begin
                exp_we   = e1 ? r1_we : r0_we;
                exp_addr = (e1 ? r1_addr : r0_addr) & 32'hFFFF_FFFC;
                exp_din  = e1 ? r1_wdata : r0_wdata;
                if (exp_we == 4'h0) begin
                    item.due  = c + 1 + int'(RD_LAT);
                    item.data = sh[exp_addr[11:2]];
                    if (e1) q1.push_back(item);
                    else    q0.push_back(item);
                end else begin
                    sh[exp_addr[11:2]] = merge(sh[exp_addr[11:2]], exp_din, exp_we);
                end
            end
            if (owner < 0) begin
                if (r0_req && r1_req) owner = 1 - last;
                else if (r0_req)      owner = 0;
                else if (r1_req)      owner = 1;
                cnt = 0;
            end else begin
                me_req = (owner == 0) ? r0_req : r1_req;
                ot_req = (owner == 0) ? r1_req : r0_req;
                if (!me_req) begin
                    owner = ot_req ? 1 - owner : -1;
                    cnt   = 0;
                end else begin
                    last = owner;
                    cnt++;
                    if (cnt == int'(MAX_BURST)) begin
                        cnt = 0;
                        if (ot_req) owner = 1 - owner;
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++; $display("FAIL rand_drain pending %0d/%0d want 0/0", q0.size(), q1.size());
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_solo_stream();
        test_write();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter that shares the single PL-side BRAM port (port B of the PS-shared audio BRAM) between the DMA refresh reader (requester 0) and a second engine such as a synth/capture buffer writer (requester 1). It sits between the requesters and the block-design `BRAM_PORTB_0_*` pins. It sequences grants round-robin with bounded bursts, registers every BRAM-facing signal, and routes read data back to the issuing requester after the fixed BRAM read latency.

## Interface
Parameters:
- `ADDR_W`, 32: BRAM byte-address width.
- `DATA_W`, 32: BRAM word width.
- `RD_LAT`, 2: cycles from `BRAM_en` high to valid `BRAM_dout`; legal range 1..4.
- `MAX_BURST`, 4: maximum consecutive beats per grant while the other requester waits; legal range 1..255.

Ports (`rK_*` exists for K = 0 and K = 1):
- `clk` in 1: system clock (FCLK_CLK0); also drives `BRAM_clk`.
- `rst` in 1: reset. Synchronous, active-high. One clock; all state is on `clk`.
- `rK_req` in 1: beat request; held with its fields until acked.
- `rK_we` in 4: byte write enables; 0 = read beat.
- `rK_addr` in ADDR_W: byte address.
- `rK_wdata` in DATA_W: write data.
- `rK_ack` out 1: beat accepted on this rising edge.
- `rK_rvalid` out 1: one-cycle pulse, read data valid.
- `rK_rdata` out DATA_W: read data, meaningful only while `rK_rvalid` is high.
- `BRAM_addr` out ADDR_W, `BRAM_din` out DATA_W, `BRAM_we` out 4, `BRAM_en` out 1, `BRAM_clk` out 1, `BRAM_rst` out 1.
- `BRAM_dout` in DATA_W.

## Operation
- FSM states: IDLE, OWN0, OWN1. Also a `last` flag (last-served requester) and an 8-bit beat counter `beats`.
- IDLE:
  - No acks in this state.
  - Any request moves to OWN of the requester; if both request, go to the one ≠ `last`.
  - `beats` ← 0.
- OWNk:
  - `rK_ack` = `rK_req` (combinational); the other requester's ack = 0.
  - Each acked beat increments `beats` and sets `last` = k.
- Transitions out of OWNk, evaluated on each edge:
  - `rK_req` low with the other requesting → OWNother, `beats` ← 0.
  - `rK_req` low with no other request → IDLE.
  - Acked beat makes `beats` == MAX_BURST with the other requesting → OWNother, `beats` ← 0.
  - Acked beat makes `beats` == MAX_BURST with no other request → stay, `beats` ← 0.
  - Otherwise stay.
- Issue registers, loaded on an acked beat:
  - `BRAM_en` = 1, `BRAM_addr` = {`rK_addr`[ADDR_W-1:2], 2'b00}, `BRAM_din` = `rK_wdata`, `BRAM_we` = `rK_we`.
  - With no acked beat: `BRAM_en` = 0, `BRAM_we` = 0; addr and din hold their values.
- Read tracking:
  - A shift register of depth RD_LAT carries {valid, id}, loaded with {1, k} for read beats (`we` == 0).
  - At the tail, `rK_rvalid` = valid && id == k, and `rK_rdata` = `BRAM_dout` (combinational from the BRAM).
  - Write beats produce no rvalid.
- Pass-throughs: `BRAM_clk` = `clk`, `BRAM_rst` = `rst`.

## Timing
- Reset values: all acks 0, rvalids 0, rdata 0, `BRAM_en` 0, `BRAM_we` 0, `BRAM_addr` 0, `BRAM_din` 0; state IDLE; `last` = 1, so requester 0 wins the first tie; `beats` 0; tracking pipe cleared.
- Arbitration bubble: one cycle. A request first seen in IDLE at cycle t is acked at t+1 at the earliest.
- Direct handover OWNk → OWNother has no bubble.
- Beat acked at edge t: `BRAM_en` high during cycle t+1. For reads, `rK_rvalid` is high during cycle t+1+RD_LAT.
- Throughput: one beat per cycle while the owner keeps `req` high. The order of rvalids equals the order of acks.
- Simultaneous events:
  - The owner drops `req` in the same cycle the other raises it: handover, no bubble.
  - MAX_BURST = 1 with both requesting: strict alternation, one beat each.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset). A beat acked at the reset edge is not issued.
- Requester fields may change only after ack. Changing fields while `req` is high and unacked is a protocol violation; the bench asserts it never happens.

## Test plan
- Reset hold: 3 cycles of `rst` = 1 with both requesters active → all outputs 0, no ack; after release `r0_ack` first.
- Single read: RD_LAT = 2; `r0_req` with addr 0x13, we 0 raised in IDLE at cycle 0 → ack at cycle 1; `BRAM_en` = 1 with `BRAM_addr` = 0x10 in cycle 2; `r0_rvalid` in cycle 4 with the model word 0xCAFE0010.
- Contention: both request continuously after reset, MAX_BURST = 4 → port 0 gets 4 beats, then port 1 gets 4 with no bubble, alternating; no ack overlap.
- Write: `r1_we` = 4'hF, addr 0x20, wdata 0xDEADBEEF → `BRAM_we` = F, `BRAM_din` = 0xDEADBEEF for one cycle; no `r1_rvalid`.
- Solo stream: port 0 alone for 10 beats, addresses 0x00..0x24 → 10 consecutive acks, no bubble at the beat-4/8 wraps, 10 rvalids in order.
- Mid-burst reset: `rst` asserted while 2 reads are in flight → no rvalid on either port afterwards; BRAM outputs at reset values on the next cycle.
